// File: rtl/median_window_filter.sv
// 3x3 median filter over a raster-order frame, two line buffers and a 2-stage pipeline.
// Optional MED_BYPASS_EN adds a 'bypass' input that forwards the window centre instead of the median.
module median_window_filter #(
  parameter int IMG_DIM    = 20,
  parameter int BIT_LENGTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BIT_LENGTH-1:0] in_pixel,
`ifdef MED_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic                  out_valid,
  output logic [BIT_LENGTH-1:0] out_pixel,
  output logic [4:0]            out_row,
  output logic [4:0]            out_col,
  output logic                  frame_done
);

  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_DIM - 1);
  localparam logic [CW-1:0] LAST_CTR = CW'(IMG_DIM - 2);

  logic                  byp_in;
`ifdef MED_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  // Input position counters
  logic [CW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] in_col_q, in_col_d;

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2, indexed by column
  logic [BIT_LENGTH-1:0] lb0_q [IMG_DIM];
  logic [BIT_LENGTH-1:0] lb1_q [IMG_DIM];

  // Window: index row*3+col, row 0 oldest line, col 2 newest pixel
  logic [BIT_LENGTH-1:0] win_q [9];
  logic [BIT_LENGTH-1:0] win_d [9];
  logic                  win_valid_q, win_valid_d;
  logic [CW-1:0]         win_row_q, win_row_d;
  logic [CW-1:0]         win_col_q, win_col_d;
  logic                  win_byp_q, win_byp_d;

  // Stage 1: registered window values
  logic [BIT_LENGTH-1:0] s1_q [9];
  logic                  s1_valid_q;
  logic [CW-1:0]         s1_row_q, s1_col_q;
  logic                  s1_byp_q;

  // Stage 2: outputs
  logic                  out_valid_q, out_valid_d;
  logic [BIT_LENGTH-1:0] out_pixel_q, out_pixel_d;
  logic [CW-1:0]         out_row_q, out_row_d;
  logic [CW-1:0]         out_col_q, out_col_d;
  logic                  frame_done_q, frame_done_d;

  logic [BIT_LENGTH-1:0] med;
  logic [BIT_LENGTH-1:0] sel_pixel;
  logic [3:0]            rank;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_row_d = in_row_q;
    in_col_d = in_col_q;
    if (in_valid) begin
      if (in_col_q == LAST_IDX) begin
        in_col_d = '0;
        in_row_d = (in_row_q == LAST_IDX) ? '0 : in_row_q + CW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3+1];
        win_d[r*3 + 1] = win_q[r*3+2];
      end
      win_d[2] = lb1_q[in_col_q];
      win_d[5] = lb0_q[in_col_q];
      win_d[8] = in_pixel;
    end
    // Window is complete only once two full rows and two columns of the current row are in
    win_valid_d = in_valid && (in_row_q >= CW'(2)) && (in_col_q >= CW'(2));
    win_row_d   = in_row_q - CW'(1);
    win_col_d   = in_col_q - CW'(1);
    win_byp_d   = byp_in;
  end

  // Median = element whose stable rank (ties broken by index) is 4 among the 9
  always_comb begin
    med  = s1_q[4];
    rank = '0;
    for (int i = 0; i < 9; i++) begin
      // NOTE: blocking '=' here because rank is a running combinational sum, not state.
      rank = '0;
      for (int j = 0; j < 9; j++) begin
        if (j != i) begin
          if ((s1_q[j] < s1_q[i]) || ((s1_q[j] == s1_q[i]) && (j < i))) rank = rank + 4'd1;
        end
      end
      if (rank == 4'd4) med = s1_q[i];
    end
  end

  always_comb begin
    sel_pixel    = s1_byp_q ? s1_q[4] : med;
    out_valid_d  = s1_valid_q;
    out_pixel_d  = s1_valid_q ? sel_pixel : out_pixel_q;
    out_row_d    = s1_valid_q ? s1_row_q : out_row_q;
    out_col_d    = s1_valid_q ? s1_col_q : out_col_q;
    frame_done_d = s1_valid_q && (s1_row_q == LAST_CTR) && (s1_col_q == LAST_CTR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_row_q     <= '0;
      in_col_q     <= '0;
      win_valid_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      in_row_q     <= in_row_d;
      in_col_q     <= in_col_d;
      win_valid_q  <= win_valid_d;
      s1_valid_q   <= win_valid_q;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: line buffers and data pipeline carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      lb0_q[in_col_q] <= in_pixel;
    end
    win_q     <= win_d;
    win_row_q <= win_row_d;
    win_col_q <= win_col_d;
    win_byp_q <= win_byp_d;
    s1_q      <= win_q;
    s1_row_q  <= win_row_q;
    s1_col_q  <= win_col_q;
    s1_byp_q  <= win_byp_q;
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_median_window_filter.sv
// Directed bench for median_window_filter: frames are driven, outputs captured at negedge and
// compared per output against hand values or a sort-based median model. Define MED_BYPASS_EN to test bypass.
module tb_median_window_filter;

  localparam int N   = 20;
  localparam int NO  = (N - 2) * (N - 2);

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [4:0] in_pixel;
`ifdef MED_BYPASS_EN
  logic       bypass;
`endif
  logic       out_valid;
  logic [4:0] out_pixel;
  logic [4:0] out_row;
  logic [4:0] out_col;
  logic       frame_done;

  median_window_filter #(.IMG_DIM(N), .BIT_LENGTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
`ifdef MED_BYPASS_EN
    .bypass     (bypass),
`endif
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int row;
    int col;
    int pix;
    int fd;
    int cyc;
  } out_t;

  out_t outq[$];
  int   sampq[$];
  int   stray_fd = 0;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      out_t o;
      o.row = int'(out_row);
      o.col = int'(out_col);
      o.pix = int'(out_pixel);
      o.fd  = int'(frame_done);
      o.cyc = cyc;
      outq.push_back(o);
    end else if (frame_done !== 1'b0) begin
      stray_fd++;
    end
  end

  logic [4:0] img [N][N];
  int         ramp_ref [NO];

  task automatic send_pixel(input logic [4:0] p, input logic byp);
    @(negedge clk);
    in_valid = 1'b1;
    in_pixel = p;
`ifdef MED_BYPASS_EN
    bypass   = byp;
`else
    if (byp) in_pixel = p;
`endif
    // Sampling edge is the next posedge; cyc will read one higher after it
    sampq.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // gapped=1 applies the repeating valid pattern 1,0,0,1
  task automatic send_frame(input bit gapped, input logic byp, input int npix);
    int pp = 0;
    for (int k = 0; k < npix; k++) begin
      while (gapped && ((pp % 4 == 1) || (pp % 4 == 2))) begin
        idle(1);
        pp++;
      end
      send_pixel(img[k / N][k % N], byp);
      pp++;
    end
  endtask

  task automatic clear_capture();
    outq.delete();
    sampq.delete();
  endtask

  function automatic int model_med(input int r, input int c);
    int v[9];
    int t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[i*3+j] = int'(img[r-1+i][c-1+j]);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8 - a; b++)
        if (v[b] > v[b+1]) begin
          t = v[b]; v[b] = v[b+1]; v[b+1] = t;
        end
    return v[4];
  endfunction

  // mode 0: constant cval; mode 1: median model; mode 2: window centre (bypass)
  task automatic check_frame(input int base, input int fidx, input int mode, input int cval);
    int r, c, e;
    out_t o;
    for (int k = 0; k < NO && (base + k) < outq.size(); k++) begin
      r = 1 + k / (N - 2);
      c = 1 + k % (N - 2);
      o = outq[base + k];
      e = (mode == 0) ? cval : (mode == 1) ? model_med(r, c) : int'(img[r][c]);
      check($sformatf("row#%0d", k), o.row, r);
      check($sformatf("col#%0d", k), o.col, c);
      check($sformatf("pix(%0d,%0d)", r, c), o.pix, e);
      check($sformatf("frame_done(%0d,%0d)", r, c), o.fd, (k == NO - 1) ? 1 : 0);
      check($sformatf("latency(%0d,%0d)", r, c), o.cyc, sampq[fidx * N * N + (r + 1) * N + (c + 1)] + 2);
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = 5'(v);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = 5'((r + c) % 32);
  endtask

  task automatic fill_impulse();
    fill_const(0);
    img[5][5] = 5'd31;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int perm[9];
    perm = '{5, 2, 7, 0, 8, 3, 6, 1, 4};
    reset    = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
`ifdef MED_BYPASS_EN
    bypass   = 1'b0;
`endif
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    reset = 1'b0;
    idle(2);

    // All 7s immediately followed by the impulse frame, no gap between frames
    clear_capture();
    fill_const(7);
    send_frame(1'b0, 1'b0, N * N);
    fill_impulse();
    send_frame(1'b0, 1'b0, N * N);
    idle(6);
    check("count_7s_impulse", outq.size(), 2 * NO);
    check_frame(0, 0, 0, 7);
    check_frame(NO, 1, 0, 0);
    idle(3);
    check("hold_valid", out_valid, 0);
    check("hold_row", out_row, 18);
    check("hold_col", out_col, 18);
    check("hold_pixel", out_pixel, 0);

    // Window around (1,1) holds 0..8, rest 0
    clear_capture();
    fill_const(0);
    for (int i = 0; i < 9; i++) img[i / 3][i % 3] = 5'(perm[i]);
    send_frame(1'b0, 1'b0, N * N);
    idle(6);
    check("count_perm", outq.size(), NO);
    if (outq.size() > 0) check("median_0_to_8", outq[0].pix, 4);
    check_frame(0, 0, 1, 0);

    // Ramp, continuous then gapped
    clear_capture();
    fill_ramp();
    send_frame(1'b0, 1'b0, N * N);
    idle(6);
    check("count_ramp", outq.size(), NO);
    check_frame(0, 0, 1, 0);
    for (int k = 0; k < NO; k++) ramp_ref[k] = (k < outq.size()) ? outq[k].pix : -1;

    clear_capture();
    send_frame(1'b1, 1'b0, N * N);
    idle(6);
    check("count_ramp_gapped", outq.size(), NO);
    check_frame(0, 0, 1, 0);
    for (int k = 0; k < NO && k < outq.size(); k++)
      check($sformatf("ramp_same#%0d", k), outq[k].pix, ramp_ref[k]);

    // Reset after 150 pixels, then an all-3s frame
    send_frame(1'b0, 1'b0, 150);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_pixel", out_pixel, 0);
    check("midrst_out_row", out_row, 0);
    check("midrst_out_col", out_col, 0);
    check("midrst_frame_done", frame_done, 0);
    reset = 1'b0;
    clear_capture();
    idle(2);
    check("post_rst_no_output", outq.size(), 0);
    fill_const(3);
    send_frame(1'b0, 1'b0, N * N);
    idle(6);
    check("count_3s", outq.size(), NO);
    check_frame(0, 0, 0, 3);

`ifdef MED_BYPASS_EN
    clear_capture();
    fill_impulse();
    send_frame(1'b0, 1'b1, N * N);
    idle(6);
    check("count_bypass", outq.size(), NO);
    if (outq.size() > 76) check("bypass_5_5", outq[76].pix, 31);
    check_frame(0, 0, 2, 0);
    bypass = 1'b0;
`endif

    check("stray_frame_done", stray_fd, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/median_window_filter.md
MEDIAN_WINDOW_FILTER -- requirements
Module: median_window_filter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  in_pixel is valid this cycle.
REQ-004 SHALL have port: in_pixel  input  5  pixel value, raster order, 20x20 frame.
REQ-005 SHALL have port: out_valid  output  1  out_pixel/out_row/out_col are valid.
REQ-006 SHALL have port: out_pixel  output  5  3x3 median of the window centred at (out_row,out_col).
REQ-007 SHALL have port: out_row  output  5  centre row, 1..18.
REQ-008 SHALL have port: out_col  output  5  centre column, 1..18.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse with the final output of a frame.
REQ-010 SHALL have parameter: IMG_DIM, default 20, frame width and height in pixels.
REQ-011 SHALL have parameter: BIT_LENGTH, default 5, pixel width.

Function
REQ-012 SHALL keep input counters in_row/in_col (0..19); each accepted pixel advances in_col, wraps 19->0 and increments in_row; (19,19) wraps to (0,0).
REQ-013 SHALL accept a pixel only on cycles with in_valid=1; no backpressure; idle gaps of any length are allowed anywhere.
REQ-014 SHALL hold two previous rows in line buffers of IMG_DIM entries each and a 3x3 window shift register updated only on accepted pixels.
REQ-015 SHALL consider the window complete when the accepted pixel is at (r,c) with r>=2 and c>=2; the centre is then (r-1,c-1).
REQ-016 SHALL never emit border centres (row or column 0 or 19): exactly 324 outputs per frame.
REQ-017 SHALL use a 2-stage pipeline: stage 1 registers the 9 window values, stage 2 registers the median.
REQ-018 SHALL assert out_valid in the cycle after the second rising edge following the completing pixel's sampling edge (latency 2), whether or not in_valid continues.
REQ-019 SHALL compute the median as the 5th smallest of the 9 unsigned values, with duplicates counted individually.
REQ-020 SHALL hold out_pixel/out_row/out_col at their last values while out_valid=0.
REQ-021 SHALL pulse frame_done together with the output for centre (18,18) only.
REQ-022 SHALL treat back-to-back frames seamlessly; line-buffer data from the previous frame never produces an output, because rows 0-1 of the new frame are never complete windows.

Reset
REQ-023 SHALL on reset clear in_row, in_col, both pipeline valid bits, out_valid, frame_done, out_pixel, out_row and out_col to 0.
REQ-024 SHALL not require line-buffer or window contents to be cleared.
REQ-025 SHALL, on reset mid-frame, discard in-flight results (no out_valid in the 2 cycles after reset) and treat the next accepted pixel as (0,0).

Configuration
REQ-026 SHALL support macro MED_BYPASS_EN; when defined, add input port bypass (1 bit, sampled with the completing pixel), and bypass=1 makes out_pixel equal the window centre value with identical timing and valid/frame_done behaviour.
REQ-027 SHALL, when MED_BYPASS_EN is undefined, have no bypass port and always output the median.

Verification
REQ-028 SHALL cover: frame of all 7s, in_valid continuous -> 324 outputs of 7, first at (1,1) 2 cycles after pixel (2,2) is sampled; frame_done with (18,18).
REQ-029 SHALL cover: all 0s except pixel (5,5)=31 -> every output 0.
REQ-030 SHALL cover: window around (1,1) loaded with values 0..8 in any order, rest 0 -> output (1,1)=4.
REQ-031 SHALL cover: in_valid toggling 1,0,0,1 over a ramp frame (pixel=(row+col) mod 32) -> results identical to the continuous run, each output 2 cycles after its completing pixel.
REQ-032 SHALL cover: reset asserted after 150 pixels, then a full all-3s frame -> no outputs for 2 cycles after reset, then 324 outputs of 3.
REQ-033 SHALL cover (MED_BYPASS_EN): bypass=1 on the REQ-029 frame -> output (5,5)=31, all other outputs 0.
